// File: rtl/program_loader.sv
// rtl/program_loader.sv - byte-stream boot loader that writes 16-bit words into program memory
module program_loader #(
  parameter int AWIDTH = 10,
  parameter int DWIDTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_wr,
  output logic [AWIDTH-1:0] mem_addr,
  output logic [DWIDTH-1:0] mem_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [AWIDTH:0]   words_written
);

  typedef enum logic [3:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  // Largest image that fits in program memory, in words.
  localparam logic [16:0] MAX_WORDS = 17'(1 << AWIDTH);

  state_t      state;
  state_t      state_next;
  logic [15:0] len;
  logic [7:0]  csum;
  logic [16:0] length_now;
  logic        last_word;

  // Length as it will be once the low byte currently on byte_in is stored.
  assign length_now = {1'b0, len[15:8], byte_in};
  // The word being written in WRITE is the final one of the image.
  assign last_word  = ((17'(words_written) + 17'd1) == {1'b0, len});

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and state-decoded outputs; byte_ready never looks at byte_valid.
  always_comb begin
    state_next = state;
    byte_ready = 1'b0;
    mem_wr     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    error      = 1'b0;
    cpu_hold   = 1'b1;
    case (state)
      S_IDLE: begin
        if (start) state_next = S_LEN_HI;
      end
      S_LEN_HI: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) state_next = S_LEN_LO;
      end
      S_LEN_LO: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) begin
          if (length_now > MAX_WORDS) begin
            state_next = S_ERROR;
          end else if (length_now == 17'd0) begin
            state_next = S_CHECK;
          end else begin
            state_next = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) state_next = S_DATA_LO;
      end
      S_DATA_LO: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) state_next = S_WRITE;
      end
      S_WRITE: begin
        mem_wr     = 1'b1;
        busy       = 1'b1;
        state_next = last_word ? S_CHECK : S_DATA_HI;
      end
      S_CHECK: begin
        byte_ready = 1'b1;
        busy       = 1'b1;
        if (byte_valid) state_next = (byte_in == csum) ? S_DONE : S_ERROR;
      end
      S_DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (start) state_next = S_LEN_HI;
      end
      S_ERROR: begin
        error = 1'b1;
        if (start) state_next = S_LEN_HI;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: length capture, word assembly, running checksum, address and word count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      len           <= '0;
      csum          <= '0;
      mem_addr      <= '0;
      mem_data      <= '0;
      words_written <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            words_written <= '0;
            mem_addr      <= '0;
            csum          <= '0;
          end
        end
        S_LEN_HI: begin
          if (byte_valid) len[15:8] <= byte_in;
        end
        S_LEN_LO: begin
          if (byte_valid) len[7:0] <= byte_in;
        end
        S_DATA_HI: begin
          if (byte_valid) begin
            mem_data[DWIDTH-1:8] <= byte_in;
            csum                 <= csum ^ byte_in;
          end
        end
        S_DATA_LO: begin
          if (byte_valid) begin
            mem_data[7:0] <= byte_in;
            csum          <= csum ^ byte_in;
          end
        end
        S_WRITE: begin
          // Natural wrap past the top address; the length limit stops any write there.
          mem_addr      <= mem_addr + AWIDTH'(1);
          words_written <= words_written + (AWIDTH + 1)'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - randomized self-checking bench for program_loader
module tb_program_loader;
  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic          mem_wr;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_data;
  logic          cpu_hold;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   words_written;

  program_loader #(.AWIDTH(AW), .DWIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .byte_in(byte_in), .byte_valid(byte_valid),
    .byte_ready(byte_ready), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_data(mem_data),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
    .words_written(words_written)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int hold_bad = 0;

  logic [AW+15:0] wr_q[$];
  logic [7:0]     stream[$];
  logic [AW+15:0] exp_wr[$];
  logic           exp_done;
  logic           exp_err;
  int             exp_words;
  int             exp_addr;

  // Observe writes and flag any cycle where a load runs with the CPU released.
  always @(negedge clk) begin
    if (rst && mem_wr) wr_q.push_back({mem_addr, mem_data});
    if (busy && !cpu_hold) hold_bad++;
  end

  // Reference: decode the stream format directly into expected writes and outcome.
  task automatic model();
    int n;
    logic [7:0] cs;
    cs = 8'h00;
    exp_wr.delete();
    n = {stream[0], stream[1]};
    if (n > (1 << AW)) begin
      exp_err = 1'b1; exp_done = 1'b0; exp_words = 0; exp_addr = 0;
      return;
    end
    for (int i = 0; i < n; i++) begin
      exp_wr.push_back({AW'(i), stream[2+2*i], stream[3+2*i]});
      cs = cs ^ stream[2+2*i] ^ stream[3+2*i];
    end
    exp_words = n;
    exp_addr  = n % (1 << AW);
    exp_done  = (cs == stream[2+2*n]);
    exp_err   = !exp_done;
  endtask

  task automatic make_image(input int n, input bit bad);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    stream.delete();
    stream.push_back(8'(n >> 8));
    stream.push_back(8'(n));
    repeat (2 * n) begin
      b = 8'($urandom);
      cs = cs ^ b;
      stream.push_back(b);
    end
    if (bad) cs = cs ^ 8'($urandom_range(255, 1));
    stream.push_back(cs);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    repeat (gap) begin
      byte_in = 8'($urandom);
      @(negedge clk);
    end
    byte_in = b;
    byte_valid = 1'b1;
    t = 0;
    while (!byte_ready && t < 64) begin
      @(negedge clk);
      t++;
    end
    if (!byte_ready) begin
      checks++; fails++;
      $display("FAIL byte_accept timeout: byte_ready=%b required 1 for byte %h", byte_ready, b);
      byte_valid = 1'b0;
      return;
    end
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic send_range(input int first, input int last, input int gmin, input int gmax);
    for (int i = first; i <= last; i++) send_byte(stream[i], $urandom_range(gmax, gmin));
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++;
    if ({byte_ready, mem_wr, busy, done, error, cpu_hold} !== 6'b000001 ||
        mem_addr !== '0 || mem_data !== '0 || words_written !== '0) begin
      fails++;
      $display("FAIL reset_values got rdy/wr/busy/done/err/hold=%b addr=%h data=%h ww=%0d required 000001/0/0/0",
               {byte_ready, mem_wr, busy, done, error, cpu_hold}, mem_addr, mem_data, words_written);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (byte_ready !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL idle_not_ready got byte_ready=%b busy=%b required 0 0", byte_ready, busy);
    end
  endtask

  task automatic test_normal();
    stream = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'h41};
    model();
    wr_q.delete();
    pulse_start();
    checks++;
    if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
      fails++;
      $display("FAIL normal_busy got busy=%b hold=%b required 1 1", busy, cpu_hold);
    end
    send_range(0, 3, 0, 0);
    checks++;
    if (mem_wr !== 1'b1 || mem_addr !== 10'd0 || mem_data !== 16'h1234) begin
      fails++;
      $display("FAIL normal_latency got wr=%b addr=%h data=%h required 1 000 1234", mem_wr, mem_addr, mem_data);
    end
    send_range(4, 8, 0, 0);
    checks++;
    if (wr_q.size() !== 3) begin
      fails++;
      $display("FAIL normal_write_count got %0d required 3", wr_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_q[i] !== exp_wr[i]) begin
          fails++;
          $display("FAIL normal_write%0d got %h required %h", i, wr_q[i], exp_wr[i]);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0 || words_written !== 11'd3 || busy !== 1'b0) begin
      fails++;
      $display("FAIL normal_final got done=%b hold=%b err=%b ww=%0d busy=%b required 1 0 0 3 0",
               done, cpu_hold, error, words_written, busy);
    end
    // Bytes offered while DONE must be refused without side effects.
    byte_in = 8'h5A;
    byte_valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (byte_ready !== 1'b0 || done !== 1'b1 || wr_q.size() !== 3) begin
        fails++;
        $display("FAIL done_refuses got ready=%b done=%b writes=%0d required 0 1 3", byte_ready, done, wr_q.size());
      end
    end
    byte_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    stream = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'h41};
    model();
    pulse_start();
    wr_q.delete();
    send_range(0, stream.size() - 1, 1, 3);
    checks++;
    if (wr_q.size() !== exp_wr.size()) begin
      fails++;
      $display("FAIL bp_write_count got %0d required %0d", wr_q.size(), exp_wr.size());
    end else begin
      foreach (exp_wr[i]) begin
        checks++;
        if (wr_q[i] !== exp_wr[i]) begin
          fails++;
          $display("FAIL bp_write%0d got %h required %h", i, wr_q[i], exp_wr[i]);
        end
      end
    end
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0 || words_written !== 11'd3) begin
      fails++;
      $display("FAIL bp_final got done=%b err=%b hold=%b ww=%0d required 1 0 0 3", done, error, cpu_hold, words_written);
    end
  endtask

  task automatic test_bad_checksum();
    stream = '{8'h00, 8'h01, 8'hBE, 8'hEF, 8'h00};
    pulse_start();
    wr_q.delete();
    send_range(0, 4, 0, 1);
    checks++;
    if (wr_q.size() !== 1 || wr_q[0] !== {10'd0, 16'hBEEF}) begin
      fails++;
      $display("FAIL badcs_write got count=%0d first=%h required 1 000beef", wr_q.size(), wr_q.size() > 0 ? wr_q[0] : '0);
    end
    checks++;
    if (error !== 1'b1 || cpu_hold !== 1'b1 || done !== 1'b0) begin
      fails++;
      $display("FAIL badcs_final got err=%b hold=%b done=%b required 1 1 0", error, cpu_hold, done);
    end
  endtask

  task automatic test_edge_lengths();
    stream = '{8'h00, 8'h00, 8'h00};
    pulse_start();
    wr_q.delete();
    send_range(0, 2, 0, 0);
    checks++;
    if (wr_q.size() !== 0 || done !== 1'b1 || words_written !== '0) begin
      fails++;
      $display("FAIL zero_len got writes=%0d done=%b ww=%0d required 0 1 0", wr_q.size(), done, words_written);
    end
    stream = '{8'h04, 8'h01};
    pulse_start();
    wr_q.delete();
    send_range(0, 1, 0, 0);
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || byte_ready !== 1'b0) begin
      fails++;
      $display("FAIL too_long got err=%b busy=%b ready=%b required 1 0 0", error, busy, byte_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wr_q.size() !== 0 || error !== 1'b1) begin
      fails++;
      $display("FAIL too_long_nowrite got writes=%0d err=%b required 0 1", wr_q.size(), error);
    end
  endtask

  task automatic test_reset_mid_load();
    stream = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'h41};
    model();
    pulse_start();
    send_range(0, 3, 0, 0);
    rst = 1'b0;
    #1;
    checks++;
    if ({byte_ready, mem_wr, busy, done, error, cpu_hold} !== 6'b000001 ||
        mem_addr !== '0 || mem_data !== '0 || words_written !== '0) begin
      fails++;
      $display("FAIL midreset_values got flags=%b addr=%h data=%h ww=%0d required 000001/0/0/0",
               {byte_ready, mem_wr, busy, done, error, cpu_hold}, mem_addr, mem_data, words_written);
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    wr_q.delete();
    pulse_start();
    send_range(0, stream.size() - 1, 0, 2);
    checks++;
    if (wr_q.size() !== 3 || wr_q[0] !== exp_wr[0] || wr_q[1] !== exp_wr[1] || wr_q[2] !== exp_wr[2]) begin
      fails++;
      $display("FAIL midreset_reload got count=%0d required 3 matching writes", wr_q.size());
    end
    checks++;
    if (done !== 1'b1 || cpu_hold !== 1'b0 || words_written !== 11'd3) begin
      fails++;
      $display("FAIL midreset_final got done=%b hold=%b ww=%0d required 1 0 3", done, cpu_hold, words_written);
    end
  endtask

  task automatic test_restart();
    make_image(1, 1'b0);
    model();
    hold_bad = 0;
    pulse_start();
    checks++;
    if (cpu_hold !== 1'b1 || done !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL restart_hold got hold=%b done=%b busy=%b required 1 0 1", cpu_hold, done, busy);
    end
    wr_q.delete();
    send_range(0, 1, 0, 0);
    pulse_start();
    @(negedge clk);
    checks++;
    if (busy !== 1'b1 || byte_ready !== 1'b1 || words_written !== '0) begin
      fails++;
      $display("FAIL ignored_start got busy=%b ready=%b ww=%0d required 1 1 0", busy, byte_ready, words_written);
    end
    send_range(2, 4, 0, 0);
    checks++;
    if (wr_q.size() !== 1 || wr_q[0] !== exp_wr[0] || done !== 1'b1 || hold_bad !== 0) begin
      fails++;
      $display("FAIL restart_final got writes=%0d done=%b hold_drops=%0d required 1 1 0", wr_q.size(), done, hold_bad);
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 7; k++) begin
      if (k == 6) make_image(1 << AW, 1'b0);
      else make_image($urandom_range(40, 1), ($urandom_range(2, 0) == 0));
      model();
      pulse_start();
      wr_q.delete();
      send_range(0, stream.size() - 1, 0, 2);
      checks++;
      if (wr_q.size() !== exp_wr.size()) begin
        fails++;
        $display("FAIL rand%0d_write_count got %0d required %0d", k, wr_q.size(), exp_wr.size());
      end else begin
        foreach (exp_wr[i]) begin
          if (wr_q[i] !== exp_wr[i]) begin
            checks++; fails++;
            $display("FAIL rand%0d_write%0d got %h required %h", k, i, wr_q[i], exp_wr[i]);
          end
        end
      end
      checks++;
      if (done !== exp_done || error !== exp_err || cpu_hold !== !exp_done ||
          words_written !== (AW + 1)'(exp_words) || mem_addr !== AW'(exp_addr)) begin
        fails++;
        $display("FAIL rand%0d_final got done=%b err=%b hold=%b ww=%0d addr=%0d required %b %b %b %0d %0d",
                 k, done, error, cpu_hold, words_written, mem_addr, exp_done, exp_err, !exp_done, exp_words, exp_addr);
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_normal();
    test_backpressure();
    test_bad_checksum();
    test_edge_lengths();
    test_reset_mid_load();
    test_restart();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
Boot loader that writes a program image into the CPU's program memory before execution starts. The CPU only reads program memory; this block is the writing side. It accepts a byte stream over a valid/ready handshake, assembles big-endian 16-bit instruction words and writes them to sequential addresses from 0. It holds the CPU in reset until the image has loaded and its checksum has verified.

Parameters:
AWIDTH, 10, program memory address width; the maximum image size is 2^AWIDTH words.
DWIDTH, 16, instruction word width; fixed at 2 bytes per word.

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-low (0 = reset)
start  input  1  one-cycle pulse that begins a load; honoured only in IDLE, DONE and ERROR
byte_in  input  8  incoming stream byte
byte_valid  input  1  byte_in is valid
byte_ready  output  1  loader accepts byte_in this cycle
mem_wr  output  1  program memory write strobe, one cycle per word
mem_addr  output  AWIDTH  program memory write address
mem_data  output  DWIDTH  program memory write data
cpu_hold  output  1  keeps the CPU in reset while high
busy  output  1  a load is in progress
done  output  1  the image loaded and verified
error  output  1  the load aborted
words_written  output  AWIDTH+1  count of words written in the current load

Behaviour:
- Reset values (rst low):
  - state = IDLE.
  - byte_ready, mem_wr, busy, done, error = 0.
  - mem_addr, mem_data, words_written = 0.
  - cpu_hold = 1.
  - Internal length, word-assembly and checksum registers = 0.
- Handshake: a byte is accepted on a rising edge where byte_valid and byte_ready are both 1. byte_ready is a registered state decode and does not depend on byte_valid. It is 1 only in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK. A gap in byte_valid stalls the FSM in its current state with no side effects.
- Stream format:
  - Length high byte, then length low byte: N, the number of words.
  - N words, each sent high byte first.
  - One checksum byte: the XOR of all 2N payload bytes. Length bytes are not included.
- FSM states and transitions:
  - IDLE: on start, clear words_written, mem_addr and checksum; set busy=1 and cpu_hold=1; go to LEN_HI.
  - LEN_HI: on accept, store N[15:8]; go to LEN_LO.
  - LEN_LO: on accept, store N[7:0], then evaluate:
    - N > 2^AWIDTH: go to ERROR; no write occurs.
    - N == 0: go to CHECK.
    - Otherwise: go to DATA_HI.
  - DATA_HI: on accept, latch the high byte and XOR it into the checksum; go to DATA_LO.
  - DATA_LO: on accept, latch the low byte and XOR it into the checksum; go to WRITE.
  - WRITE (one cycle, byte_ready=0):
    - mem_wr=1, mem_addr = current address, mem_data = the assembled word.
    - Next cycle: address increments and words_written increments.
    - If words_written+1 == N, go to CHECK; otherwise go to DATA_HI.
  - CHECK: on accept, compare the byte to the checksum. Equal goes to DONE; different goes to ERROR.
  - DONE: done=1, busy=0, cpu_hold=0. Hold here until start arrives, which restarts as from IDLE (done clears, cpu_hold returns to 1).
  - ERROR: error=1, busy=0, cpu_hold=1. Hold here until start arrives, which restarts as from IDLE.
- Write-pulse and address rules:
  - mem_wr is high for exactly one cycle per word.
  - Latency from acceptance of a word's low byte to its mem_wr pulse is 1 cycle.
  - mem_addr increments by exactly 1 per write, starting from 0.
  - mem_addr wraps to 0 after writing address 2^AWIDTH-1; a write to the wrapped address never occurs, because N <= 2^AWIDTH.
- Boundary conditions:
  - start in any busy state is ignored.
  - Bytes offered in IDLE, DONE or ERROR are not accepted (byte_ready=0).
  - rst asserted mid-load aborts immediately to reset values. Memory contents already written are not reverted.
  - Maximum image N = 2^AWIDTH: exactly 2^AWIDTH writes occur and words_written ends at 2^AWIDTH.

Test Plan:
1. Normal load:
   - Stimulus: rst pulse, start, then bytes 00 03 12 34 AB CD 00 01 41.
   - Required: writes 0x1234@0, 0xABCD@1, 0x0001@2, one mem_wr cycle each.
   - Required: done=1, cpu_hold=0, words_written=3, error=0.
2. Backpressure: same stream with byte_valid low for 1–3 random cycles between bytes -> identical writes and final state; no duplicate or skipped bytes.
3. Bad checksum: stream 00 01 BE EF 00 -> a single write 0xBEEF@0, then error=1, cpu_hold=1, done=0.
4. Edge lengths:
   - Stream 00 00 00: no mem_wr, done=1.
   - Stream 04 01 (N=1025, AWIDTH=10): error=1 right after LEN_LO, no mem_wr.
5. Reset mid-load: assert rst after the 4th byte of test 1 -> all outputs take reset values at once and cpu_hold=1. A fresh start with the full stream then completes as in test 1.
6. Restart and ignored start:
   - start pulse during DATA_HI is ignored.
   - After DONE, a start reloads a new 1-word image at address 0, and cpu_hold returns to 1 for the whole reload.
